// File: rtl/capture_window_ctrl_if.sv
// rtl/capture_window_ctrl_if.sv - saved-sample valid/ack handshake between the measurement sequencer and the loop filter
interface capture_window_ctrl_if #(
  parameter int SEQ_WIDTH = 8
) ();

  // Producer holds sample_valid until the consumer raises sample_ack.
  logic                 sample_valid;
  logic [SEQ_WIDTH-1:0] sample_seq;
  logic                 sample_ack;

  // Sequencer side.
  modport master (
    output sample_valid,
    output sample_seq,
    input  sample_ack
  );

  // Loop-filter side.
  modport slave (
    input  sample_valid,
    input  sample_seq,
    output sample_ack
  );

endinterface

// File: rtl/capture_window_ctrl.sv
// rtl/capture_window_ctrl.sv - ADPLL frequency-measurement window sequencer (clear, count, save, present)
module capture_window_ctrl #(
  parameter int WIN_WIDTH   = 8,
  parameter int CLR_TIMEOUT = 4,
  parameter int SEQ_WIDTH   = 8
) (
  input  logic                 fpga_clk_i,
  input  logic                 reset_n_i,
  input  logic                 enable_i,
  input  logic                 ref_edge_i,
  input  logic [WIN_WIDTH-1:0] window_len_i,
  input  logic                 counter_cleared_i,
  output logic                 counter_clear_o,
  output logic                 counter_run_o,
  output logic                 save_trigger_o,
  output logic                 clear_err_o,
  capture_window_ctrl_if.master smp
);

  // Measurement phases. Every output is a pure decode of the current phase,
  // so IDLE (the reset phase) drives all pulses low.
  localparam logic [2:0] ST_IDLE     = 3'd0;
  localparam logic [2:0] ST_CLEAR    = 3'd1;
  localparam logic [2:0] ST_WAIT_CLR = 3'd2;
  localparam logic [2:0] ST_ARM      = 3'd3;
  localparam logic [2:0] ST_COUNT    = 3'd4;
  localparam logic [2:0] ST_SAVE     = 3'd5;
  localparam logic [2:0] ST_SETTLE   = 3'd6;
  localparam logic [2:0] ST_VALID    = 3'd7;

  // Timeout counter counts 0..CLR_TIMEOUT-1 while waiting for the clear to land.
  localparam int                   TMO_W    = (CLR_TIMEOUT > 1) ? $clog2(CLR_TIMEOUT) : 1;
  localparam logic [TMO_W-1:0]     TMO_LAST = TMO_W'(CLR_TIMEOUT - 1);
  localparam logic [WIN_WIDTH-1:0] WIN_ONE  = WIN_WIDTH'(1);

  logic [2:0]           state_q;
  logic [2:0]           state_d;
  logic [WIN_WIDTH-1:0] win_cnt_q;
  logic [TMO_W-1:0]     tmo_q;
  logic [SEQ_WIDTH-1:0] seq_q;
  logic                 err_q;

  logic arm_edge;
  logic cnt_edge;
  logic clr_timeout;
  logic sample_accept;
  logic [WIN_WIDTH-1:0] win_load;

  // A dropped enable aborts the window before the save, so edges only
  // count while enable is still high.
  assign arm_edge      = (state_q == ST_ARM)   && enable_i && ref_edge_i;
  assign cnt_edge      = (state_q == ST_COUNT) && enable_i && ref_edge_i;
  assign clr_timeout   = (state_q == ST_WAIT_CLR) && enable_i &&
                         !counter_cleared_i && (tmo_q == TMO_LAST);
  assign sample_accept = (state_q == ST_VALID) && smp.sample_ack;

  // A zero window length would never close, so it behaves like a single edge.
  assign win_load = (window_len_i == '0) ? WIN_ONE : window_len_i;

  // Next-phase selection; enable only aborts phases before the save is issued.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: begin
        if (enable_i) state_d = ST_CLEAR;
      end
      ST_CLEAR: begin
        state_d = enable_i ? ST_WAIT_CLR : ST_IDLE;
      end
      ST_WAIT_CLR: begin
        if (!enable_i)              state_d = ST_IDLE;
        else if (counter_cleared_i) state_d = ST_ARM;
        else if (tmo_q == TMO_LAST) state_d = ST_IDLE;
      end
      ST_ARM: begin
        if (!enable_i)       state_d = ST_IDLE;
        else if (ref_edge_i) state_d = ST_COUNT;
      end
      ST_COUNT: begin
        if (!enable_i)                           state_d = ST_IDLE;
        else if (ref_edge_i && win_cnt_q == WIN_ONE) state_d = ST_SAVE;
      end
      ST_SAVE: begin
        state_d = ST_SETTLE;
      end
      ST_SETTLE: begin
        state_d = ST_VALID;
      end
      ST_VALID: begin
        if (smp.sample_ack) state_d = enable_i ? ST_CLEAR : ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Phase register.
  always_ff @(posedge fpga_clk_i or negedge reset_n_i) begin
    if (!reset_n_i) state_q <= ST_IDLE;
    else            state_q <= state_d;
  end

  // Reference-edge down-counter: window length is captured only on the arming edge.
  always_ff @(posedge fpga_clk_i or negedge reset_n_i) begin
    if (!reset_n_i)    win_cnt_q <= '0;
    else if (arm_edge) win_cnt_q <= win_load;
    else if (cnt_edge) win_cnt_q <= win_cnt_q - WIN_ONE;
  end

  // Clear-confirmation timeout: restarts on every clear pulse, saturates at the last count.
  always_ff @(posedge fpga_clk_i or negedge reset_n_i) begin
    if (!reset_n_i)                                        tmo_q <= '0;
    else if (state_q == ST_CLEAR)                          tmo_q <= '0;
    else if (state_q == ST_WAIT_CLR && tmo_q != TMO_LAST)  tmo_q <= tmo_q + 1'b1;
  end

  // Sample sequence number advances on each accepted sample and wraps naturally.
  always_ff @(posedge fpga_clk_i or negedge reset_n_i) begin
    if (!reset_n_i)         seq_q <= '0;
    else if (sample_accept) seq_q <= seq_q + 1'b1;
  end

  // Sticky clear-failure flag; only reset removes it, retries continue regardless.
  always_ff @(posedge fpga_clk_i or negedge reset_n_i) begin
    if (!reset_n_i)       err_q <= 1'b0;
    else if (clr_timeout) err_q <= 1'b1;
  end

  assign counter_clear_o  = (state_q == ST_CLEAR);
  assign counter_run_o    = (state_q == ST_COUNT);
  assign save_trigger_o   = (state_q == ST_SAVE);
  assign clear_err_o      = err_q;
  assign smp.sample_valid = (state_q == ST_VALID);
  assign smp.sample_seq   = seq_q;

endmodule

// File: tb/tb_capture_window_ctrl.sv
// tb/tb_capture_window_ctrl.sv - randomized directed-step bench for capture_window_ctrl
module tb_capture_window_ctrl;

  localparam int WIN_WIDTH   = 8;
  localparam int CLR_TIMEOUT = 4;
  localparam int SEQ_WIDTH   = 8;

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic                 en;
  logic                 ref_edge;
  logic [WIN_WIDTH-1:0] win_len;
  logic                 cleared;
  logic                 ack;
  logic                 clr;
  logic                 run;
  logic                 save;
  logic                 err;

  int   vectors     = 0;
  int   miscompares = 0;
  int   exp_seq     = 0;
  logic exp_err     = 1'b0;

  capture_window_ctrl_if #(.SEQ_WIDTH(SEQ_WIDTH)) smp ();

  assign smp.sample_ack = ack;

  capture_window_ctrl #(
    .WIN_WIDTH  (WIN_WIDTH),
    .CLR_TIMEOUT(CLR_TIMEOUT),
    .SEQ_WIDTH  (SEQ_WIDTH)
  ) dut (
    .fpga_clk_i       (clk),
    .reset_n_i        (rst_n),
    .enable_i         (en),
    .ref_edge_i       (ref_edge),
    .window_len_i     (win_len),
    .counter_cleared_i(cleared),
    .counter_clear_o  (clr),
    .counter_run_o    (run),
    .save_trigger_o   (save),
    .clear_err_o      (err),
    .smp              (smp)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_clr"},   clr,              0);
    chk({tag, "_run"},   run,              0);
    chk({tag, "_save"},  save,             0);
    chk({tag, "_valid"}, smp.sample_valid, 0);
    chk({tag, "_seq"},   smp.sample_seq,   0);
    chk({tag, "_err"},   err,              0);
  endtask

  // One measurement. d = WAIT_CLR cycles with cleared low (< CLR_TIMEOUT).
  // mode: 0 normal, 1 drop enable after abort_at edges, 2 reset after abort_at edges,
  // 3 drop enable while the sample is valid.
  task automatic window(input int len, input int gmin, input int gmax, input int d,
                        input int ackw, input int mode, input int abort_at);
    int n;
    int budget;
    n        = (len == 0) ? 1 : len;
    win_len  = WIN_WIDTH'(len);
    ref_edge = 1'b0;
    ack      = 1'b0;
    budget   = 0;
    while (clr !== 1'b1 && budget < 40) begin
      tick();
      budget++;
    end
    chk("clear_pulse", clr, 1);
    chk("err_hold", err, exp_err);
    cleared = (d == 0);
    tick();
    chk("clear_one_cycle", clr, 0);
    repeat (d) begin
      chk("waitclr_run", run, 0);
      ref_edge = 1'($urandom % 2);
      tick();
    end
    cleared  = 1'b1;
    ref_edge = 1'($urandom % 2);
    tick();
    ref_edge = 1'b0;
    chk("arm_run", run, 0);
    chk("arm_err", err, exp_err);
    repeat ($urandom_range(0, 2)) begin
      tick();
      chk("arm_idle_run", run, 0);
    end
    ref_edge = 1'b1;
    tick();
    ref_edge = 1'b0;
    win_len  = WIN_WIDTH'($urandom);
    chk("run_start", run, 1);
    for (int k = 1; k <= n; k++) begin
      repeat ($urandom_range(gmin, gmax)) begin
        ack = 1'($urandom % 2);
        tick();
        chk("count_run", run, 1);
        chk("count_save", save, 0);
      end
      ack = 1'b0;
      if (mode == 1 && k == abort_at + 1) begin
        en       = 1'b0;
        ref_edge = 1'b1;
        tick();
        ref_edge = 1'b0;
        chk("abort_run", run, 0);
        chk("abort_save", save, 0);
        repeat (3) begin
          tick();
          chk("abort_idle_clr", clr, 0);
          chk("abort_idle_save", save, 0);
          chk("abort_idle_valid", smp.sample_valid, 0);
          chk("abort_seq", smp.sample_seq, exp_seq);
        end
        return;
      end
      if (mode == 2 && k == abort_at + 1) begin
        rst_n = 1'b0;
        #1;
        exp_seq = 0;
        exp_err = 1'b0;
        chk_all_zero("midreset");
        tick();
        chk("midreset_hold_clr", clr, 0);
        rst_n = 1'b1;
        return;
      end
      ref_edge = 1'b1;
      tick();
      ref_edge = 1'b0;
      if (k < n) begin
        chk("edge_run", run, 1);
        chk("edge_save", save, 0);
      end else begin
        chk("run_drop", run, 0);
        chk("save_pulse", save, 1);
      end
    end
    ack      = 1'($urandom % 2);
    ref_edge = 1'($urandom % 2);
    tick();
    chk("settle_save", save, 0);
    chk("settle_valid", smp.sample_valid, 0);
    chk("settle_run", run, 0);
    ack      = 1'($urandom % 2);
    ref_edge = 1'($urandom % 2);
    tick();
    ack = 1'b0;
    chk("valid_latency", smp.sample_valid, 1);
    chk("valid_seq", smp.sample_seq, exp_seq);
    if (mode == 3) en = 1'b0;
    repeat (ackw) begin
      ref_edge = 1'($urandom % 2);
      win_len  = WIN_WIDTH'($urandom);
      tick();
      chk("valid_hold", smp.sample_valid, 1);
      chk("valid_no_clear", clr, 0);
    end
    ack      = 1'b1;
    ref_edge = 1'b0;
    tick();
    ack     = 1'b0;
    exp_seq = (exp_seq + 1) % (1 << SEQ_WIDTH);
    chk("ack_valid_drop", smp.sample_valid, 0);
    chk("ack_seq", smp.sample_seq, exp_seq);
    chk("ack_next_clear", clr, {31'd0, en});
    if (mode == 3) begin
      repeat (3) begin
        tick();
        chk("disabled_idle_clr", clr, 0);
        chk("disabled_idle_valid", smp.sample_valid, 0);
      end
    end
  endtask

  initial begin
    rst_n    = 1'b0;
    en       = 1'b1;
    ref_edge = 1'b0;
    win_len  = WIN_WIDTH'(4);
    cleared  = 1'b1;
    ack      = 1'b0;

    // Reset held with enable high: everything quiet.
    repeat (3) tick();
    chk_all_zero("reset");
    rst_n = 1'b1;
    tick();
    chk("first_clear", clr, 1);

    // Nominal window of 4 edges spaced 10 clocks.
    window(4, 9, 9, 0, 3, 0, 0);

    // Zero and unit lengths both close on the first counted edge.
    window(0, 0, 3, 0, 1, 0, 0);
    window(1, 0, 3, 0, 0, 0, 0);

    // Clear confirmed late, including on the last allowed cycle: no error.
    window(3, 0, 2, 1, 0, 0, 0);
    window(2, 0, 2, CLR_TIMEOUT - 1, 2, 0, 0);

    // Clear never confirmed: error after CLR_TIMEOUT waiting cycles, then retry.
    begin
      int budget;
      budget  = 0;
      cleared = 1'b0;
      while (clr !== 1'b1 && budget < 40) begin
        tick();
        budget++;
      end
      chk("tmo_clear", clr, 1);
      tick();
      repeat (CLR_TIMEOUT - 1) begin
        chk("tmo_wait_clr", clr, 0);
        chk("tmo_wait_err", err, 0);
        tick();
      end
      chk("tmo_last_err", err, 0);
      tick();
      exp_err = 1'b1;
      chk("tmo_err_set", err, 1);
      chk("tmo_idle_clr", clr, 0);
      tick();
      chk("tmo_retry_clear", clr, 1);
    end
    window(2, 0, 2, 0, 1, 0, 0);

    // Enable dropped mid-count, and on the final edge of a window.
    window(5, 1, 3, 0, 0, 1, 2);
    en = 1'b1;
    window(3, 0, 1, 0, 0, 1, 2);
    en = 1'b1;

    // Enable dropped while valid: handshake still completes, then idle.
    window(2, 0, 2, 0, 4, 3, 0);
    en = 1'b1;

    // Long backpressure.
    window(2, 0, 2, 0, 100, 0, 0);

    // Enough random samples to wrap the sequence number.
    for (int i = 0; i < 260; i++) begin
      window($urandom_range(0, 3), 0, 1, $urandom_range(0, CLR_TIMEOUT - 1),
             $urandom_range(0, 3), 0, 0);
    end

    // Asynchronous reset mid-window, then a clean measurement.
    window(6, 1, 2, 0, 0, 2, 3);
    window(2, 0, 1, 0, 0, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
